// File: rtl/register_file_writer.sv
// 32 x 32-bit register file with a pending-write scoreboard and a busy counter.
// Define WRITE_BYPASS_EN to forward same-cycle write-back data and pending state to the read ports.
module register_file_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic [ADDR_W:0]   busy_count
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pending_next;
  logic [NREGS-1:0]  wr_sel;
  logic [NREGS-1:0]  issue_sel;

  function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + (ADDR_W+1)'(v[i]);
    return c;
  endfunction

  // Index 0 is never selected, so register 0 stays zero and never pends.
  always_comb begin
    wr_sel    = '0;
    issue_sel = '0;
    if (wr_en && wr_addr != '0)       wr_sel[wr_addr]     = 1'b1;
    if (issue_en && issue_rd != '0)   issue_sel[issue_rd] = 1'b1;
    // Issue is applied after the clear so a new producer wins over write-back.
    pending_next = (pending & ~wr_sel) | issue_sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pending    <= '0;
      busy_count <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_sel[i]) regs[i] <= wr_data;
      end
      pending    <= pending_next;
      busy_count <= popcount(pending_next);
    end
  end

  always_comb begin
    rs1_data    = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    rs2_data    = (rs2_addr == '0) ? '0 : regs[rs2_addr];
    rs1_pending = (rs1_addr == '0) ? 1'b0 : pending[rs1_addr];
    rs2_pending = (rs2_addr == '0) ? 1'b0 : pending[rs2_addr];
`ifdef WRITE_BYPASS_EN
    // wr_sel is never set for index 0, so forwarding cannot disturb register 0.
    if (wr_sel[rs1_addr]) begin
      rs1_data    = wr_data;
      rs1_pending = issue_sel[rs1_addr];
    end
    if (wr_sel[rs2_addr]) begin
      rs2_data    = wr_data;
      rs2_pending = issue_sel[rs2_addr];
    end
`endif
  end

endmodule

// File: tb/tb_register_file_writer.sv
// Directed self-checking bench for register_file_writer (covers both WRITE_BYPASS_EN builds).
module tb_register_file_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_pending;
  logic        rs2_pending;
  logic [5:0]  busy_count;

  int checks = 0;
  int errors = 0;

  register_file_writer dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rs1_pending(rs1_pending),
    .rs2_pending(rs2_pending),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    issue_en = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    issue_en = 1'b0;
    issue_rd = '0;
    rs1_addr = 5'd5;
    rs2_addr = 5'd6;
    tick();
    // Strobes during reset must be ignored.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1111_1111;
    issue_en = 1'b1; issue_rd = 5'd5;
    tick();
    tick();
    check("reset_rs1_data", rs1_data, 32'h0);
    check("reset_rs1_pending", {31'b0, rs1_pending}, 32'h0);
    check("reset_busy", {26'b0, busy_count}, 32'h0);
    idle();
    #2 reset = 1'b0;

    // First write after reset, with bypass visibility before the edge.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    #1;
`ifdef WRITE_BYPASS_EN
    check("pre_edge_rs1_5", rs1_data, 32'hDEAD_BEEF);
`else
    check("pre_edge_rs1_5", rs1_data, 32'h0);
`endif
    tick();
    idle();
    check("write5_rs1", rs1_data, 32'hDEAD_BEEF);
    check("write5_rs2_6", rs2_data, 32'h0);

    // Register 0 is never written nor marked pending.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_rd = 5'd0;
    rs1_addr = 5'd0;
    tick();
    idle();
    check("r0_data", rs1_data, 32'h0);
    check("r0_pending", {31'b0, rs1_pending}, 32'h0);
    check("r0_busy", {26'b0, busy_count}, 32'h0);

    // Scoreboard set and clear.
    issue_en = 1'b1; issue_rd = 5'd3; tick();
    issue_rd = 5'd7; tick();
    idle();
    rs1_addr = 5'd3; rs2_addr = 5'd7;
    #1;
    check("busy_two", {26'b0, busy_count}, 32'd2);
    check("pend3", {31'b0, rs1_pending}, 32'h1);
    check("pend7", {31'b0, rs2_pending}, 32'h1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12; tick();
    idle();
    check("busy_after_wb3", {26'b0, busy_count}, 32'd1);
    check("wb3_data", rs1_data, 32'h12);
    check("wb3_pending", {31'b0, rs1_pending}, 32'h0);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77; tick();
    idle();
    check("busy_after_wb7", {26'b0, busy_count}, 32'd0);

    // Same-cycle issue and write to one index: data lands, pending stays set.
    issue_en = 1'b1; issue_rd = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    tick();
    idle();
    rs1_addr = 5'd9;
    #1;
    check("same9_data", rs1_data, 32'h55);
    check("same9_pending", {31'b0, rs1_pending}, 32'h1);
    check("same9_busy", {26'b0, busy_count}, 32'd1);
    issue_en = 1'b1; issue_rd = 5'd9; tick();
    idle();
    check("reset_bit_again_busy", {26'b0, busy_count}, 32'd1);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; tick();
    idle();
    check("clear_clear_bit_busy", {26'b0, busy_count}, 32'd1);

    // Forwarding of data and pending to a read port before the edge.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44; tick();
    idle();
    issue_en = 1'b1; issue_rd = 5'd4; tick();
    idle();
    check("busy_4_9", {26'b0, busy_count}, 32'd2);
    rs2_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hA5A5_A5A5;
    #1;
`ifdef WRITE_BYPASS_EN
    check("bypass_rs2_data", rs2_data, 32'hA5A5_A5A5);
    check("bypass_rs2_pending", {31'b0, rs2_pending}, 32'h0);
`else
    check("bypass_rs2_data", rs2_data, 32'h44);
    check("bypass_rs2_pending", {31'b0, rs2_pending}, 32'h1);
`endif
    tick();
    idle();
    check("wb4_data", rs2_data, 32'hA5A5_A5A5);
    check("wb4_pending", {31'b0, rs2_pending}, 32'h0);
    check("wb4_busy", {26'b0, busy_count}, 32'd1);

    // Pend every register, then reset asynchronously between edges.
    for (int i = 1; i < 32; i++) begin
      issue_en = 1'b1; issue_rd = 5'(i); tick();
    end
    idle();
    rs1_addr = 5'd31; rs2_addr = 5'd1;
    #1;
    check("busy_full", {26'b0, busy_count}, 32'd31);
    check("pend31", {31'b0, rs1_pending}, 32'h1);
    check("pend1", {31'b0, rs2_pending}, 32'h1);
    rs1_addr = 5'd9; rs2_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hBAD0_BAD0;
    #1;
    reset = 1'b1;
    #1;
    check("async_busy", {26'b0, busy_count}, 32'd0);
    check("async_rs2_data", rs2_data, 32'h0);
    check("async_rs2_pending", {31'b0, rs2_pending}, 32'h0);
`ifndef WRITE_BYPASS_EN
    check("async_rs1_data", rs1_data, 32'h0);
`endif
    check("async_rs1_pending", {31'b0, rs1_pending}, 32'h0);
    issue_en = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    check("held_rs1_data", rs1_data, 32'h0);
    check("held_busy", {26'b0, busy_count}, 32'd0);
    #2 reset = 1'b0;

    // First operations after release take effect at the next edge.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    issue_en = 1'b1; issue_rd = 5'd2;
    tick();
    idle();
    rs2_addr = 5'd2;
    #1;
    check("post_reset_write", rs1_data, 32'h99);
    check("post_reset_issue", {31'b0, rs2_pending}, 32'h1);
    check("post_reset_busy", {26'b0, busy_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_writer.md
REGISTER_FILE_WRITER -- requirements
Module: register_file_writer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port wr_en, input, 1, write-back strobe.
REQ-004 SHALL have port wr_addr, input, 5, destination register index.
REQ-005 SHALL have port wr_data, input, 32, write-back data.
REQ-006 SHALL have port issue_en, input, 1, instruction issue strobe; marks destination pending.
REQ-007 SHALL have port issue_rd, input, 5, destination index of the issuing instruction.
REQ-008 SHALL have ports rs1_addr and rs2_addr, input, 5 each, read-port indices.
REQ-009 SHALL have ports rs1_data and rs2_data, output, 32 each, read-port data.
REQ-010 SHALL have ports rs1_pending and rs2_pending, output, 1 each, high when the addressed register awaits write-back.
REQ-011 SHALL have port busy_count, output, 6, number of registers currently pending (0..31).

Function
REQ-012 SHALL hold 32 x 32-bit registers; register 0 SHALL always read 0 and SHALL never be written or marked pending.
REQ-013 SHALL decode wr_addr to a one-hot write enable; when wr_en=1 and wr_addr!=0, the addressed register SHALL take wr_data at the next clk edge; other registers SHALL hold.
REQ-014 SHALL provide combinational reads: rsN_data equals the register addressed by rsN_addr, with zero added latency.
REQ-015 SHALL keep a 32-bit pending scoreboard: issue_en=1 with issue_rd!=0 SHALL set pending[issue_rd] at the next edge.
REQ-016 SHALL clear pending[wr_addr] at the next edge when wr_en=1.
REQ-017 When issue_en and wr_en target the same nonzero index in one cycle, the data SHALL be written and pending SHALL end set (the new producer wins).
REQ-018 SHALL drive rsN_pending combinationally from pending[rsN_addr]; index 0 SHALL give 0.
REQ-019 SHALL update busy_count on the same edge as the scoreboard, equal to the population count of pending.
REQ-020 Setting an already-set bit or clearing an already-clear bit SHALL leave busy_count unchanged; busy_count SHALL not wrap.

Reset
REQ-021 While reset=1, all registers, all pending bits and busy_count SHALL be 0, asynchronously and regardless of clk.
REQ-022 wr_en and issue_en asserted while reset=1 SHALL have no effect; an operation in progress when reset asserts SHALL be discarded.
REQ-023 After reset deasserts, the first write and issue SHALL take effect at the first following rising clk edge.
REQ-024 After reset, rs1_data, rs2_data, rs1_pending, rs2_pending and busy_count SHALL all be 0.

Configuration
REQ-025 Macro WRITE_BYPASS_EN SHALL control same-cycle forwarding.
REQ-026 With WRITE_BYPASS_EN defined: when wr_en=1, wr_addr!=0 and rsN_addr==wr_addr, rsN_data SHALL equal wr_data combinationally, and rsN_pending SHALL be 0 unless issue_en targets the same index.
REQ-027 Without WRITE_BYPASS_EN: reads SHALL return the stored value and pending bit until the clock edge completes the write.

Verification
REQ-028 Reset, then wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, one edge; rs1_addr=5 -> rs1_data=0xDEADBEEF; rs2_addr=6 -> rs2_data=0.
REQ-029 wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; issue_en=1, issue_rd=0 -> rs1_data(addr 0)=0, rs1_pending=0, busy_count=0.
REQ-030 Issue rd=3, then rd=7 -> busy_count=2, and rs1_pending=1 at addr 3; write 3 with 0x12 -> busy_count=1 and rs1_data=0x12.
REQ-031 Same cycle: issue_en with rd=9 and wr_en with addr 9, data 0x55 -> rs1_data=0x55, rs1_pending=1, busy_count=1.
REQ-032 Bypass build: wr_en=1, addr 4, data 0xA5A5A5A5, rs2_addr=4, before the edge -> rs2_data=0xA5A5A5A5; non-bypass build -> the old value.
REQ-033 Pend registers 1..31, then assert reset between clock edges -> all outputs 0 immediately, busy_count=0.
